hermes_inport: RTL and testbench
================================

# hermes_inport

Parametrised input port for the Hermes router: a credit-based flit FIFO plus the packet-framing state machine that parses header/size flits, requests a route, and drains exactly one packet per grant. One instance sits behind each of the NPORT router inputs, and also at the mesh's local injection point. Its width and depth are set per instance, so mesh edges and the local port can be sized independently of the inter-router links.

## Interface
Parameters:
- FLIT_SIZE, default hermes_pkg::FLIT_SIZE (32): flit width in bits. Must be at least 8.
- BUFFER_SIZE, default 8: FIFO depth in flits. Must be at least 2. Need not be a power of two.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset. Asynchronous, active-low.
- rx_i  input  1  upstream flit valid.
- data_i  input  FLIT_SIZE  upstream flit.
- credit_o  input-side output  1  space available; upstream may send only while high.
- req_o  output  1  routing request; the head flit is a header.
- header_o  output  FLIT_SIZE  header flit (target address) presented to the router's routing logic.
- ack_i  input  1  one-cycle grant from the routing/crossbar logic.
- tx_o  output  1  downstream flit valid.
- data_o  output  FLIT_SIZE  flit at the FIFO head.
- credit_i  input  1  downstream space; a flit is transferred when tx_o && credit_i.
- eop_o  output  1  one-cycle pulse coincident with the transfer of a packet's last flit.
- sending_o  output  1  high from grant until the last flit is transferred.

## Operation
- Write: when rx_i && credit_o, data_i is stored and count increments.
- credit_o = (count < BUFFER_SIZE). It depends on the registered count only, so a same-cycle read does not free a slot.
- Read: on a transfer, the head advances and count decrements. Pointers wrap from BUFFER_SIZE-1 to 0 by explicit compare.
- Simultaneous write and read: count is unchanged and both pointers advance.
- Packet format: header flit, then size flit (N = payload flit count, unsigned, FLIT_SIZE bits), then N payload flits.
- FSM states: IDLE, REQ, HEADER, SIZE, PAYLOAD.
  - IDLE → REQ when the FIFO is non-empty. The head flit is by definition a header.
  - REQ: req_o=1, header_o=data_o. Moves to HEADER on ack_i. Any ack_i outside REQ is ignored.
  - HEADER: tx_o = !empty. Moves to SIZE on transfer.
  - SIZE: tx_o = !empty. On transfer, the flit value is latched into the payload counter. If N=0, eop_o pulses and the FSM goes to IDLE; otherwise it goes to PAYLOAD.
  - PAYLOAD: tx_o = !empty. Each transfer decrements the counter. The transfer at counter=1 pulses eop_o and returns to IDLE.
- sending_o = state in {HEADER, SIZE, PAYLOAD}.
- An empty FIFO mid-packet stalls: tx_o=0 and the state holds.
- N = 2^FLIT_SIZE-1 must be handled with no counter overflow; the counter is FLIT_SIZE bits.
- Reset asserted mid-packet discards FIFO contents and the packet state. No recovery of a partial packet is attempted.

## Timing
- Reset values: credit_o=1, req_o=0, tx_o=0, eop_o=0, sending_o=0, header_o=0 and data_o=0 (FIFO storage cleared), count=0, state IDLE.
- A flit written in cycle t is visible at the head, and can raise req_o, in cycle t+1.
- Minimum header-to-header spacing: req_o in t+1 → ack_i at t+1 → header transfer at t+2.
- A packet of N payload flits occupies N+2 transfer cycles after the grant.
- tx_o, data_o, req_o and header_o are combinational from registered state/FIFO only; none depends combinationally on rx_i, credit_i or ack_i.
- eop_o is combinational: the last-flit transfer condition.
- Sustained throughput is 1 flit/cycle with rx_i and credit_i held high and BUFFER_SIZE ≥ 2.

## Configuration
- HERMES_INPORT_STATS_EN defined: adds output pkt_count_o (32 bits, reset 0). It increments on every eop_o and wraps 0xFFFFFFFF→0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- hermes_pkg holds FLIT_SIZE, NPORT, the port index constants, and typedef enum hermes_inport_state_t {IDLE, REQ, HEADER, SIZE, PAYLOAD}.
- One sub-module, hermes_fifo, provides parametrised storage, pointers, count, full/empty, and write/read enables.
- hermes_inport holds only the FSM, the payload counter and the stats counter.

## Test plan
- Reset, then one packet: header 0x0102, size 3, payloads 0xA,0xB,0xC, with ack_i 1 cycle after req_o and credit_i=1. Required: req_o at cycle 1; 5 flits out in order; eop_o with 0xC; sending_o low afterwards.
- Zero-size packet: header 0x0000, size 0. Required: eop_o on the size flit transfer, then IDLE; a following header raises req_o the next cycle.
- Full FIFO, BUFFER_SIZE=4, credit_i=0, rx_i held: Required: credit_o low after 4 writes, no 5th write; a single credit_i pulse raises credit_o the cycle after the read.
- Wrap-around, BUFFER_SIZE=3, 10-payload packet with random credit_i stalls: output matches input order exactly.
- Reset mid-PAYLOAD (3 of 6 flits sent): Required: all outputs at reset values; a new packet afterwards is framed correctly.
- With HERMES_INPORT_STATS_EN, back-to-back packets of sizes 0,1,2: pkt_count_o reads 3, and ack_i pulses outside REQ have no effect.

Source files
------------

// File: rtl/hermes_pkg.sv
// rtl/hermes_pkg.sv - shared Hermes router constants and input-port state type
package hermes_pkg;

    localparam int FLIT_SIZE = 32;
    localparam int NPORT     = 5;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HEADER  = 3'd2,
        SIZE    = 3'd3,
        PAYLOAD = 3'd4
    } hermes_inport_state_t;

endpackage

// File: rtl/hermes_fifo.sv
// rtl/hermes_fifo.sv - parametrised flit FIFO with explicit-compare pointer wrap
module hermes_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // Full/empty come from the registered count only, so a same-cycle read never frees a slot.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_inport.sv
// rtl/hermes_inport.sv - Hermes router input port: flit FIFO plus packet framing FSM (optional HERMES_INPORT_STATS_EN)
module hermes_inport #(
    parameter int FLIT_SIZE   = hermes_pkg::FLIT_SIZE,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    output logic [FLIT_SIZE-1:0] header_o,
    input  logic                 ack_i,
    output logic                 tx_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 eop_o,
    output logic                 sending_o
`ifdef HERMES_INPORT_STATS_EN
   ,output logic [31:0]          pkt_count_o
`endif
);

    import hermes_pkg::*;

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_REQ     = 3'(REQ);
    localparam logic [2:0] ST_HEADER  = 3'(HEADER);
    localparam logic [2:0] ST_SIZE    = 3'(SIZE);
    localparam logic [2:0] ST_PAYLOAD = 3'(PAYLOAD);

    logic [2:0]           state;
    logic [FLIT_SIZE-1:0] pay_cnt;
    logic                 full;
    logic                 empty;
    logic                 transfer;

    hermes_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .wr_en   (rx_i),
        .wr_data (data_i),
        .rd_en   (transfer),
        .rd_data (data_o),
        .full    (full),
        .empty   (empty)
    );

    // A non-empty head while idle is a header, so the request is raised without waiting
    // for the state register; that lets a flit written in cycle t request in cycle t+1.
    assign credit_o  = !full;
    assign req_o     = (state == ST_REQ) || (state == ST_IDLE && !empty);
    assign header_o  = data_o;
    assign sending_o = (state == ST_HEADER) || (state == ST_SIZE) || (state == ST_PAYLOAD);
    assign tx_o      = sending_o && !empty;
    assign transfer  = tx_o && credit_i;
    assign eop_o     = transfer && (((state == ST_SIZE) && (data_o == '0)) ||
                                    ((state == ST_PAYLOAD) && (pay_cnt == FLIT_SIZE'(1))));

    // Packet framing: request a route, then drain header, size and exactly N payload flits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            pay_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state <= ack_i ? ST_HEADER : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_i) begin
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (transfer) begin
                        state <= ST_SIZE;
                    end
                end
                ST_SIZE: begin
                    if (transfer) begin
                        pay_cnt <= data_o;
                        state   <= (data_o == '0) ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (transfer) begin
                        pay_cnt <= pay_cnt - 1'b1;
                        if (pay_cnt == FLIT_SIZE'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HERMES_INPORT_STATS_EN
    // Completed-packet counter; wraps naturally at 32 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_count_o <= '0;
        end else if (eop_o) begin
            pkt_count_o <= pkt_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hermes_inport.sv
// tb/tb_hermes_inport.sv - randomized self-checking bench for hermes_inport
module tb_hermes_inport;

    localparam int FS = 8;
    localparam int BS = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx_i = 1'b0;
    logic [FS-1:0] data_i = '0;
    logic          credit_o;
    logic          req_o;
    logic [FS-1:0] header_o;
    logic          ack_i = 1'b0;
    logic          tx_o;
    logic [FS-1:0] data_o;
    logic          credit_i = 1'b0;
    logic          eop_o;
    logic          sending_o;
`ifdef HERMES_INPORT_STATS_EN
    logic [31:0]   pkt_count_o;
`endif

    hermes_inport #(
        .FLIT_SIZE   (FS),
        .BUFFER_SIZE (BS)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rx_i      (rx_i),
        .data_i    (data_i),
        .credit_o  (credit_o),
        .req_o     (req_o),
        .header_o  (header_o),
        .ack_i     (ack_i),
        .tx_o      (tx_o),
        .data_o    (data_o),
        .credit_i  (credit_i),
        .eop_o     (eop_o),
        .sending_o (sending_o)
`ifdef HERMES_INPORT_STATS_EN
       ,.pkt_count_o (pkt_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the port is a FIFO of flits plus "is a packet granted, and how far into it".
    logic [FS-1:0] src_q[$];
    logic [FS-1:0] mq[$];
    bit            granted = 0;
    int            pos = 0;
    int            rem = 0;
    int            pkts = 0;
    int            p_rx = 100;
    int            p_cr = 100;
    int            p_ack = 100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic add_pkt(input logic [FS-1:0] hdr, input int n);
        src_q.push_back(hdr);
        src_q.push_back(FS'(n));
        for (int i = 0; i < n; i++) begin
            src_q.push_back(FS'($urandom));
        end
    endtask

    task automatic model_clear();
        mq.delete();
        src_q.delete();
        granted = 0;
        pos = 0;
        rem = 0;
        pkts = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_credit", 32'(credit_o), 32'd1);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_tx", 32'(tx_o), 32'd0);
        check("rst_eop", 32'(eop_o), 32'd0);
        check("rst_sending", 32'(sending_o), 32'd0);
        check("rst_header", 32'(header_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
`ifdef HERMES_INPORT_STATS_EN
        check("rst_pkt_count", pkt_count_o, 32'd0);
`endif
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance the model at the rising edge.
    task automatic cycle();
        bit e_credit, e_req, e_tx, xfer, e_last, accept;
        logic [FS-1:0] f;
        rx_i     = (src_q.size() > 0) && ($urandom_range(99) < p_rx);
        data_i   = rx_i ? src_q[0] : FS'($urandom);
        credit_i = ($urandom_range(99) < p_cr);
        ack_i    = ($urandom_range(99) < p_ack);
        #1;
        e_credit = mq.size() < BS;
        e_req    = !granted && mq.size() > 0;
        e_tx     = granted && mq.size() > 0;
        xfer     = e_tx && credit_i;
        e_last   = xfer && ((pos == 1 && mq[0] == '0) || (pos >= 2 && rem == 1));
        check("credit_o", 32'(credit_o), 32'(e_credit));
        check("req_o", 32'(req_o), 32'(e_req));
        check("tx_o", 32'(tx_o), 32'(e_tx));
        check("eop_o", 32'(eop_o), 32'(e_last));
        check("sending_o", 32'(sending_o), 32'(granted));
        if (mq.size() > 0) check("data_o", 32'(data_o), 32'(mq[0]));
        if (e_req) check("header_o", 32'(header_o), 32'(mq[0]));
`ifdef HERMES_INPORT_STATS_EN
        check("pkt_count_o", pkt_count_o, 32'(pkts));
`endif
        @(posedge clk_i);
        accept = rx_i && e_credit;
        if (e_req && ack_i) begin
            granted = 1;
            pos = 0;
        end
        if (xfer) begin
            f = mq.pop_front();
            if (pos == 1) rem = int'(f);
            else if (pos >= 2) rem--;
            pos++;
            if (e_last) begin
                granted = 0;
                pkts++;
            end
        end
        if (accept) begin
            mq.push_back(data_i);
            void'(src_q.pop_front());
        end
        @(negedge clk_i);
    endtask

    task automatic run_idle(input int budget);
        int i = 0;
        while ((src_q.size() > 0 || mq.size() > 0 || granted) && i < budget) begin
            cycle();
            i++;
        end
        check("drain_timeout", 32'(src_q.size() + mq.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        rx_i = 1'b0;
        ack_i = 1'b0;
        credit_i = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int i;
        do_reset();

        // Single packet, immediate grant, free downstream.
        add_pkt(FS'(8'h12), 3);
        src_q[2] = 8'h0A; src_q[3] = 8'h0B; src_q[4] = 8'h0C;
        run_idle(50);

        // Zero-size packet followed by another header.
        add_pkt(FS'(8'h00), 0);
        add_pkt(FS'(8'h21), 1);
        run_idle(50);

        // Fill with downstream blocked and no grant, then drain.
        p_cr = 0; p_ack = 0;
        add_pkt(FS'(8'h33), 5);
        for (int k = 0; k < 8; k++) cycle();
        p_cr = 40; p_ack = 50;
        run_idle(200);

        // Wrap-around with a 10-payload packet under random stalls.
        p_rx = 70; p_cr = 50; p_ack = 30;
        add_pkt(FS'($urandom), 10);
        run_idle(400);

        // Random packet stream including ack pulses outside the request phase.
        for (int k = 0; k < 20; k++) add_pkt(FS'($urandom), $urandom_range(0, 6));
        run_idle(3000);

        // Largest payload count the flit width can express.
        p_rx = 100; p_cr = 100; p_ack = 100;
        add_pkt(FS'(8'h7E), (1 << FS) - 1);
        run_idle(1000);

        // Reset in the middle of a payload, then a fresh packet.
        add_pkt(FS'(8'h44), 6);
        i = 0;
        while (!(granted && pos == 5) && i < 50) begin
            cycle();
            i++;
        end
        check("mid_pkt_reached", 32'(pos), 32'd5);
        do_reset();
        add_pkt(FS'(8'h55), 2);
        run_idle(50);

        // Back-to-back sizes 0,1,2 with stray acks.
        p_ack = 60;
        add_pkt(FS'(8'h01), 0);
        add_pkt(FS'(8'h02), 1);
        add_pkt(FS'(8'h03), 2);
        run_idle(100);
        for (int k = 0; k < 3; k++) cycle();
        check("pkts_after_reset", 32'(pkts), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
